bip_control_unit: RTL and testbench

- Control unit for the accumulator datapath.
- Sits directly upstream of the accumulator-input 3:1 multiplexer and drives its 2-bit select.
- Also drives the ALU operand select, the ALU operation, the accumulator write-enable and the data RAM strobes.
- Owns the program counter and a FETCH/EXEC/HALT state machine; every instruction takes two clocks.

---
 rtl/bip_control_unit_pkg.sv | 37 +++
 rtl/bip_instr_decoder.sv | 61 ++++++
 rtl/bip_control_unit.sv | 101 ++++++++++
 tb/tb_bip_control_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_control_unit_pkg.sv
// Shared encodings for the accumulator-machine control unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: opcode constants, accumulator-input mux selects, ALU op/operand
// selects and FSM state encodings.
package bip_control_unit_pkg;

    localparam int OPC_BITS = 5;

    // Opcodes (Instr[15:11])
    localparam logic [OPC_BITS-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_BITS-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_BITS-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_BITS-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_BITS-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_BITS-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_BITS-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_BITS-1:0] OPC_SUBI = 5'b00111;

    // Accumulator-input mux select; encoding 3 is never produced
    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_RAM = 2'd2;

    // ALU operand-B select and operation
    localparam logic SELB_RAM = 1'b0;
    localparam logic SELB_IMM = 1'b1;
    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/bip_instr_decoder.sv
// Opcode to datapath-strobe decoder for the accumulator machine.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; all outputs are forced to 0 unless exec is high.
// Ports: exec (gate), opcode -> sel_a, sel_b, op, wr_acc, wr_ram, rd_ram.
module bip_instr_decoder
    import bip_control_unit_pkg::*;
(
    input  logic                exec,
    input  logic [OPC_BITS-1:0] opcode,
    output logic [1:0]          sel_a,
    output logic                sel_b,
    output logic                op,
    output logic                wr_acc,
    output logic                wr_ram,
    output logic                rd_ram
);

    always_comb begin
        sel_a  = SEL_ALU;
        sel_b  = SELB_RAM;
        op     = OP_ADD;
        wr_acc = 1'b0;
        wr_ram = 1'b0;
        rd_ram = 1'b0;
        if (exec) begin
            unique case (opcode)
                OPC_STO: wr_ram = 1'b1;
                OPC_LD: begin
                    rd_ram = 1'b1;
                    sel_a  = SEL_RAM;
                    wr_acc = 1'b1;
                end
                OPC_LDI: begin
                    sel_a  = SEL_IMM;
                    wr_acc = 1'b1;
                end
                OPC_ADD: begin
                    rd_ram = 1'b1;
                    wr_acc = 1'b1;
                end
                OPC_ADDI: begin
                    sel_b  = SELB_IMM;
                    wr_acc = 1'b1;
                end
                OPC_SUB: begin
                    rd_ram = 1'b1;
                    op     = OP_SUB;
                    wr_acc = 1'b1;
                end
                OPC_SUBI: begin
                    sel_b  = SELB_IMM;
                    op     = OP_SUB;
                    wr_acc = 1'b1;
                end
                // HLT and undefined opcodes leave every strobe low
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bip_control_unit.sv
// Control unit for the accumulator datapath: FETCH/EXEC/HALT FSM, PC, decode.
// Latency: two clocks per instruction; strobes valid only in the EXEC cycle.
// Backpressure: none; HALT is absorbing until Reset (sync, active-low).
// Ports: Clk, Reset, Instr in; PC, Operand, SelA, SelB, Op, WrAcc, WrRam,
// RdRam, Halted out. Optional: define BIP_INSTR_COUNT_EN to add InstrCount.
module bip_control_unit
    import bip_control_unit_pkg::*;
#(
    parameter int PC_W  = 11,
    parameter int OPC_W = 5,
    parameter int IW    = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [IW-1:0]   Instr,
    output logic [PC_W-1:0] PC,
    output logic [PC_W-1:0] Operand,
    output logic [1:0]      SelA,
    output logic            SelB,
    output logic            Op,
    output logic            WrAcc,
    output logic            WrRam,
    output logic            RdRam,
    output logic            Halted
`ifdef BIP_INSTR_COUNT_EN
    ,
    output logic [31:0]     InstrCount
`endif
);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q;
    logic              pc_inc;
    logic              exec;
    logic [OPC_W-1:0]  opcode;

    assign opcode  = Instr[IW-1:PC_W];
    assign exec    = (state_q == ST_EXEC);
    assign Operand = Instr[PC_W-1:0];
    assign PC      = pc_q;
    assign Halted  = (state_q == ST_HALT);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            // Natural wrap at 2^PC_W, no flag
            if (pc_inc) begin
                pc_q <= pc_q + PC_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_inc  = 1'b0;
        unique case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                // HLT freezes the PC on its own address
                if (opcode == OPC_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    pc_inc  = 1'b1;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    bip_instr_decoder u_dec (
        .exec   (exec),
        .opcode (opcode),
        .sel_a  (SelA),
        .sel_b  (SelB),
        .op     (Op),
        .wr_acc (WrAcc),
        .wr_ram (WrRam),
        .rd_ram (RdRam)
    );

`ifdef BIP_INSTR_COUNT_EN
    logic [31:0] cnt_q;

    // Counts every completed EXEC, HLT included; a reset edge overrides it
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if (exec) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign InstrCount = cnt_q;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
module tb_bip_control_unit;

    logic        Clk;
    logic        Reset;
    logic [15:0] Instr;
    logic [10:0] PC;
    logic [10:0] Operand;
    logic [1:0]  SelA;
    logic        SelB;
    logic        Op;
    logic        WrAcc;
    logic        WrRam;
    logic        RdRam;
    logic        Halted;
`ifdef BIP_INSTR_COUNT_EN
    logic [31:0] InstrCount;
`endif

    bip_control_unit dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Instr   (Instr),
        .PC      (PC),
        .Operand (Operand),
        .SelA    (SelA),
        .SelB    (SelB),
        .Op      (Op),
        .WrAcc   (WrAcc),
        .WrRam   (WrRam),
        .RdRam   (RdRam),
        .Halted  (Halted)
`ifdef BIP_INSTR_COUNT_EN
        ,
        .InstrCount (InstrCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Program ROM with synchronous read
    logic [15:0] rom [0:2047];
    always @(posedge Clk) Instr <= rom[PC];

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] a);
        return {o, a};
    endfunction

    typedef struct {
        logic [10:0] pc;
        logic [1:0]  sela;
        logic        selb;
        logic        op;
        logic        wracc;
        logic        wrram;
        logic        rdram;
        logic        halted;
        logic        is_exec;
        logic [10:0] opnd;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference decode: {sela[1:0], selb, op, wracc, wrram, rdram}
    function automatic logic [6:0] ref_decode(input logic [4:0] opc);
        case (opc)
            5'd1:    return 7'b00_0_0_0_1_0; // STO
            5'd2:    return 7'b10_0_0_1_0_1; // LD
            5'd3:    return 7'b01_0_0_1_0_0; // LDI
            5'd4:    return 7'b00_0_0_1_0_1; // ADD
            5'd5:    return 7'b00_1_0_1_0_0; // ADDI
            5'd6:    return 7'b00_0_1_1_0_1; // SUB
            5'd7:    return 7'b00_1_1_1_0_0; // SUBI
            default: return 7'b0;            // HLT, NOP
        endcase
    endfunction

    // Reference machine: advances at each rising edge, pushes the outputs
    // expected for the following cycle.
    initial begin
        logic [1:0]  m_st;   // 0 fetch, 1 exec, 2 halt
        logic [10:0] m_pc;
        logic [31:0] m_cnt;
        logic [6:0]  d;
        exp_t        e;
        m_st = 2'd0; m_pc = '0; m_cnt = '0;
        forever begin
            @(posedge Clk);
            if (!Reset) begin
                m_st = 2'd0; m_pc = '0; m_cnt = '0;
            end else begin
                case (m_st)
                    2'd0: m_st = 2'd1;
                    2'd1: begin
                        m_cnt = m_cnt + 32'd1;
                        if (rom[m_pc][15:11] == 5'd0) m_st = 2'd2;
                        else begin
                            m_st = 2'd0;
                            m_pc = m_pc + 11'd1;
                        end
                    end
                    default: ;
                endcase
            end
            d = (m_st == 2'd1) ? ref_decode(rom[m_pc][15:11]) : 7'b0;
            e.pc      = m_pc;
            e.sela    = d[6:5];
            e.selb    = d[4];
            e.op      = d[3];
            e.wracc   = d[2];
            e.wrram   = d[1];
            e.rdram   = d[0];
            e.halted  = (m_st == 2'd2);
            e.is_exec = (m_st == 2'd1);
            e.opnd    = rom[m_pc][10:0];
            e.cnt     = m_cnt;
            sb_q.push_back(e);
        end
    end

    // Compare DUT outputs against the scoreboard mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc",     32'(PC),     32'(e.pc));
                check("sela",   32'(SelA),   32'(e.sela));
                check("selb",   32'(SelB),   32'(e.selb));
                check("op",     32'(Op),     32'(e.op));
                check("wracc",  32'(WrAcc),  32'(e.wracc));
                check("wrram",  32'(WrRam),  32'(e.wrram));
                check("rdram",  32'(RdRam),  32'(e.rdram));
                check("halted", 32'(Halted), 32'(e.halted));
                if (e.is_exec) check("operand", 32'(Operand), 32'(e.opnd));
`ifdef BIP_INSTR_COUNT_EN
                check("count", InstrCount, e.cnt);
`endif
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic clear_rom(input logic [15:0] w);
        for (int i = 0; i < 2048; i++) rom[i] = w;
    endtask

    initial begin
        Reset = 1'b0;
        clear_rom(16'h0000);

        // LDI 5; ADDI 3; STO 4; HLT
        rom[0] = ins(5'd3, 11'd5);
        rom[1] = ins(5'd5, 11'd3);
        rom[2] = ins(5'd1, 11'd4);
        rom[3] = ins(5'd0, 11'd0);
        cycles(3);
        check("reset_pc", 32'(PC), 32'd0);
        check("reset_halted", 32'(Halted), 32'd0);
        check("reset_wracc", 32'(WrAcc), 32'd0);
        Reset = 1'b1;
        cycles(1);
        check("first_exec_ldi_wracc", 32'(WrAcc), 32'd1);
        check("first_exec_ldi_sela", 32'(SelA), 32'd1);
        cycles(7);
        cycles(10);
        check("halt_pc", 32'(PC), 32'd3);
        check("halt_flag", 32'(Halted), 32'd1);
`ifdef BIP_INSTR_COUNT_EN
        check("instr_count_hold", InstrCount, 32'd4);
`endif

        // Reset from HALT; LD 7; SUB 8; HLT
        Reset = 1'b0;
        clear_rom(16'h0000);
        rom[0] = ins(5'd2, 11'd7);
        rom[1] = ins(5'd6, 11'd8);
        cycles(1);
        check("halt_exit", 32'(Halted), 32'd0);
        cycles(1);
        Reset = 1'b1;
        cycles(10);

        // Undefined opcode at PC 0 behaves as NOP
        Reset = 1'b0;
        clear_rom(16'h0000);
        rom[0] = ins(5'h1F, 11'd9);
        cycles(2);
        Reset = 1'b1;
        cycles(2);
        check("nop_pc", 32'(PC), 32'd1);
        cycles(6);

        // Reset during the EXEC of an ADD
        Reset = 1'b0;
        clear_rom(16'h0000);
        for (int i = 0; i < 4; i++) rom[i] = ins(5'd4, 11'(i + 1));
        cycles(2);
        Reset = 1'b1;
        cycles(3);
        check("mid_exec_rdram", 32'(RdRam), 32'd1);
        Reset = 1'b0;
        cycles(1);
        check("mid_reset_pc", 32'(PC), 32'd0);
        check("mid_reset_wracc", 32'(WrAcc), 32'd0);
        Reset = 1'b1;
        cycles(14);

        // NOP stream across the full address space: PC wraps to 0
        Reset = 1'b0;
        clear_rom(ins(5'h1F, 11'd0));
        cycles(2);
        Reset = 1'b1;
        cycles(4094);
        check("pre_wrap_pc", 32'(PC), 32'd2047);
        cycles(2);
        check("wrap_pc", 32'(PC), 32'd0);
        cycles(4);

        @(negedge Clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
